// File: rtl/disp_stat_pkg.sv
// Shared types and constants for the display statistics capture stage.
// Saturating increment helper used by every event counter.
package disp_stat_pkg;

    typedef enum logic {
        LIVE   = 1'b0,
        FROZEN = 1'b1
    } frz_state_t;

    typedef enum logic [2:0] {
        PG_TOTAL = 3'd0,
        PG_ADD   = 3'd1,
        PG_PRICE = 3'd2,
        PG_QTY   = 3'd3,
        PG_ERR   = 3'd4,
        PG_TYPE  = 3'd5
    } page_t;

    localparam logic [7:0]  ADD_TYPE_DEFAULT = 8'h41;
    localparam logic [31:0] CNT_MAX          = 32'hFFFF_FFFF;
    localparam int          NUM_STATS        = 6;

    // Counters stick at their ceiling instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic [31:0] max);
        logic [31:0] res;
        if (cnt >= max) begin
            res = cnt;
        end else begin
            res = cnt + 32'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/display_stat_capture_rise_edge.sv
// Rising-edge detector for a debounced button level.
// Reset primes the history with the live level so a held button yields no edge.
module rise_edge (
    input  logic clk_in,
    input  logic rst_in,
    input  logic level_in,
    output logic rise_out
);

    logic prev_q;

    // Level history register; reset loads the current level rather than zero.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            prev_q <= level_in;
        end else begin
            prev_q <= level_in;
        end
    end

    assign rise_out = level_in & ~prev_q;

endmodule

// File: rtl/display_stat_capture.sv
// Debug statistics stage feeding the 7-segment driver: saturating counters,
// last-seen fields, page selection and a freeze snapshot for stable viewing.
module display_stat_capture
    import disp_stat_pkg::*;
#(
    parameter int         NUM_PAGES = 6,
    parameter logic [7:0] ADD_TYPE  = ADD_TYPE_DEFAULT,
    parameter int         CNT_W     = 32
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             msg_valid_in,
    input  logic [7:0]       msg_type_in,
    input  logic             msg_err_in,
    input  logic [31:0]      price_in,
    input  logic [31:0]      qty_in,
    input  logic             btn_next_in,
    input  logic             btn_freeze_in,
    input  logic             btn_clear_in,
    output logic [CNT_W-1:0] val_out,
    output logic [2:0]       page_out,
    output logic             frozen_out
);

    localparam logic [31:0] SAT_MAX   = CNT_MAX >> (32 - CNT_W);
    localparam logic [2:0]  LAST_PAGE = 3'(NUM_PAGES - 1);

    logic             next_rise_s;
    logic             frz_rise_s;
    logic             clr_rise_s;

    frz_state_t       frz_q, frz_d;
    logic             snap_s;
    logic [2:0]       page_q, page_d;

    logic [CNT_W-1:0] total_q, total_d;
    logic [CNT_W-1:0] add_q, add_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [31:0]      price_q, price_d;
    logic [31:0]      qty_q, qty_d;
    logic [7:0]       type_q, type_d;

    logic [31:0]      total_inc_s, add_inc_s, err_inc_s, type_ext_s;
    logic [CNT_W-1:0] live_s   [NUM_STATS];
    logic [CNT_W-1:0] shadow_q [NUM_STATS];
    logic [CNT_W-1:0] val_q, val_d;

    rise_edge u_next_edge (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .level_in (btn_next_in),
        .rise_out (next_rise_s)
    );

    rise_edge u_freeze_edge (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .level_in (btn_freeze_in),
        .rise_out (frz_rise_s)
    );

    rise_edge u_clear_edge (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .level_in (btn_clear_in),
        .rise_out (clr_rise_s)
    );

    // Live statistics next-state; a clear edge beats a same-cycle message.
    always_comb begin
        total_inc_s = sat_inc(32'(total_q), SAT_MAX);
        add_inc_s   = sat_inc(32'(add_q), SAT_MAX);
        err_inc_s   = sat_inc(32'(err_q), SAT_MAX);
        total_d     = total_q;
        add_d       = add_q;
        err_d       = err_q;
        price_d     = price_q;
        qty_d       = qty_q;
        type_d      = type_q;
        if (clr_rise_s) begin
            total_d = '0;
            add_d   = '0;
            err_d   = '0;
            price_d = 32'd0;
            qty_d   = 32'd0;
            type_d  = 8'd0;
        end else if (msg_valid_in) begin
            total_d = total_inc_s[CNT_W-1:0];
            if (msg_err_in) begin
                err_d = err_inc_s[CNT_W-1:0];
            end else begin
                price_d = price_in;
                qty_d   = qty_in;
                type_d  = msg_type_in;
                if (msg_type_in == ADD_TYPE) begin
                    add_d = add_inc_s[CNT_W-1:0];
                end else begin
                    add_d = add_q;
                end
            end
        end else begin
            total_d = total_q;
        end
    end

    // Page-ordered view of the live statistics, narrowed to the display width.
    always_comb begin
        type_ext_s               = {24'h0, type_q};
        live_s[int'(PG_TOTAL)]   = total_q;
        live_s[int'(PG_ADD)]     = add_q;
        live_s[int'(PG_PRICE)]   = price_q[CNT_W-1:0];
        live_s[int'(PG_QTY)]     = qty_q[CNT_W-1:0];
        live_s[int'(PG_ERR)]     = err_q;
        live_s[int'(PG_TYPE)]    = type_ext_s[CNT_W-1:0];
    end

    // Freeze FSM; the snapshot is taken only on the LIVE->FROZEN edge.
    always_comb begin
        frz_d  = frz_q;
        snap_s = 1'b0;
        case (frz_q)
            LIVE: begin
                if (frz_rise_s) begin
                    frz_d  = FROZEN;
                    snap_s = 1'b1;
                end else begin
                    frz_d = LIVE;
                end
            end
            FROZEN: begin
                if (frz_rise_s) begin
                    frz_d = LIVE;
                end else begin
                    frz_d = FROZEN;
                end
            end
            default: frz_d = LIVE;
        endcase
    end

    // Page selector wraps after the last page.
    always_comb begin
        if (next_rise_s) begin
            page_d = (page_q == LAST_PAGE) ? 3'd0 : page_q + 3'd1;
        end else begin
            page_d = page_q;
        end
    end

    // Display mux works from registered page/state, hence the one-cycle lag.
    always_comb begin
        val_d = '0;
        case (page_q)
            PG_TOTAL: val_d = (frz_q == FROZEN) ? shadow_q[0] : live_s[0];
            PG_ADD:   val_d = (frz_q == FROZEN) ? shadow_q[1] : live_s[1];
            PG_PRICE: val_d = (frz_q == FROZEN) ? shadow_q[2] : live_s[2];
            PG_QTY:   val_d = (frz_q == FROZEN) ? shadow_q[3] : live_s[3];
            PG_ERR:   val_d = (frz_q == FROZEN) ? shadow_q[4] : live_s[4];
            PG_TYPE:  val_d = (frz_q == FROZEN) ? shadow_q[5] : live_s[5];
            default:  val_d = '0;
        endcase
    end

    // Main state registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            frz_q   <= LIVE;
            page_q  <= 3'd0;
            total_q <= '0;
            add_q   <= '0;
            err_q   <= '0;
            price_q <= 32'd0;
            qty_q   <= 32'd0;
            type_q  <= 8'd0;
            val_q   <= '0;
        end else begin
            frz_q   <= frz_d;
            page_q  <= page_d;
            total_q <= total_d;
            add_q   <= add_d;
            err_q   <= err_d;
            price_q <= price_d;
            qty_q   <= qty_d;
            type_q  <= type_d;
            val_q   <= val_d;
        end
    end

    // Shadow copy captures pre-edge live values, so same-cycle clears are excluded.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < NUM_STATS; i++) begin
                shadow_q[i] <= '0;
            end
        end else if (snap_s) begin
            for (int i = 0; i < NUM_STATS; i++) begin
                shadow_q[i] <= live_s[i];
            end
        end else begin
            for (int i = 0; i < NUM_STATS; i++) begin
                shadow_q[i] <= shadow_q[i];
            end
        end
    end

    assign val_out    = val_q;
    assign page_out   = page_q;
    assign frozen_out = (frz_q == FROZEN);

endmodule

// File: tb/tb_display_stat_capture.sv
// Self-checking bench for display_stat_capture; a narrow second instance
// exercises counter saturation in a reachable number of messages.
module tb_display_stat_capture;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        msg_valid_in;
    logic [7:0]  msg_type_in;
    logic        msg_err_in;
    logic [31:0] price_in;
    logic [31:0] qty_in;
    logic        btn_next_in;
    logic        btn_freeze_in;
    logic        btn_clear_in;
    logic [31:0] val_out;
    logic [2:0]  page_out;
    logic        frozen_out;
    logic [3:0]  sat_val;
    logic [2:0]  sat_page;
    logic        sat_frz;

    typedef struct {
        string       name;
        logic [31:0] val;
        logic [2:0]  page;
        logic        frz;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk_in = ~clk_in;

    display_stat_capture dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .msg_valid_in  (msg_valid_in),
        .msg_type_in   (msg_type_in),
        .msg_err_in    (msg_err_in),
        .price_in      (price_in),
        .qty_in        (qty_in),
        .btn_next_in   (btn_next_in),
        .btn_freeze_in (btn_freeze_in),
        .btn_clear_in  (btn_clear_in),
        .val_out       (val_out),
        .page_out      (page_out),
        .frozen_out    (frozen_out)
    );

    display_stat_capture #(.CNT_W(4)) dut_sat (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .msg_valid_in  (msg_valid_in),
        .msg_type_in   (msg_type_in),
        .msg_err_in    (msg_err_in),
        .price_in      (price_in),
        .qty_in        (qty_in),
        .btn_next_in   (btn_next_in),
        .btn_freeze_in (btn_freeze_in),
        .btn_clear_in  (btn_clear_in),
        .val_out       (sat_val),
        .page_out      (sat_page),
        .frozen_out    (sat_frz)
    );

    task automatic clk1();
        @(negedge clk_in);
    endtask

    task automatic push(input string nm, input logic [31:0] v, input logic [2:0] p, input logic f);
        exp_t x;
        x.name = nm;
        x.val  = v;
        x.page = p;
        x.frz  = f;
        sb_q.push_back(x);
    endtask

    task automatic send_msg(input logic [7:0] t, input logic er, input logic [31:0] pr, input logic [31:0] q);
        msg_valid_in = 1'b1;
        msg_type_in  = t;
        msg_err_in   = er;
        price_in     = pr;
        qty_in       = q;
        clk1();
        msg_valid_in = 1'b0;
        msg_err_in   = 1'b0;
    endtask

    task automatic press_next();
        btn_next_in = 1'b1;
        clk1();
        btn_next_in = 1'b0;
        clk1();
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        clk1();
        clk1();
        rst_in = 1'b0;
    endtask

    task automatic test_reset();
        btn_next_in = 1'b1;
        rst_in      = 1'b1;
        repeat (3) clk1();
        rst_in = 1'b0;
        clk1();
        push("reset_state", 32'd0, 3'd0, 1'b0);
        e = sb_q.pop_front();
        n_total++;
        if ({val_out, page_out, frozen_out} !== {e.val, e.page, e.frz})
            $display("FAIL %s: val=%0h page=%0d frozen=%b, want val=%0h page=%0d frozen=%b", e.name, val_out, page_out, frozen_out, e.val, e.page, e.frz);
        else n_pass++;
        clk1();
        btn_next_in = 1'b0;
        clk1();
        push("held_next_no_edge", 32'd0, 3'd0, 1'b0);
        e = sb_q.pop_front();
        n_total++;
        if ({val_out, page_out, frozen_out} !== {e.val, e.page, e.frz})
            $display("FAIL %s: val=%0h page=%0d frozen=%b, want val=%0h page=%0d frozen=%b", e.name, val_out, page_out, frozen_out, e.val, e.page, e.frz);
        else n_pass++;
        n_total++;
        if (sat_val !== 4'd0) $display("FAIL reset_narrow: val=%0h, want 0", sat_val);
        else n_pass++;
    endtask

    task automatic test_pages();
        logic [31:0] pv [6];
        pv = '{32'd4, 32'd3, 32'd102, 32'd12, 32'd1, 32'h41};
        for (int i = 0; i < 3; i++) send_msg(8'h41, 1'b0, 32'd100 + 32'(i), 32'd10 + 32'(i));
        send_msg(8'h41, 1'b1, 32'd99, 32'd7);
        push("msg_latency_pre", 32'd3, 3'd0, 1'b0);
        e = sb_q.pop_front();
        n_total++;
        if ({val_out, page_out, frozen_out} !== {e.val, e.page, e.frz})
            $display("FAIL %s: val=%0h page=%0d frozen=%b, want val=%0h page=%0d frozen=%b", e.name, val_out, page_out, frozen_out, e.val, e.page, e.frz);
        else n_pass++;
        clk1();
        push("page0_total", pv[0], 3'd0, 1'b0);
        e = sb_q.pop_front();
        n_total++;
        if ({val_out, page_out, frozen_out} !== {e.val, e.page, e.frz})
            $display("FAIL %s: val=%0h page=%0d frozen=%b, want val=%0h page=%0d frozen=%b", e.name, val_out, page_out, frozen_out, e.val, e.page, e.frz);
        else n_pass++;
        for (int p = 1; p < 6; p++) begin
            btn_next_in = 1'b1;
            clk1();
            push("page_switch_lag", pv[p-1], 3'(p), 1'b0);
            e = sb_q.pop_front();
            n_total++;
            if ({val_out, page_out, frozen_out} !== {e.val, e.page, e.frz})
                $display("FAIL %s: val=%0h page=%0d frozen=%b, want val=%0h page=%0d frozen=%b", e.name, val_out, page_out, frozen_out, e.val, e.page, e.frz);
            else n_pass++;
            btn_next_in = 1'b0;
            clk1();
            push("page_value", pv[p], 3'(p), 1'b0);
            e = sb_q.pop_front();
            n_total++;
            if ({val_out, page_out, frozen_out} !== {e.val, e.page, e.frz})
                $display("FAIL %s: val=%0h page=%0d frozen=%b, want val=%0h page=%0d frozen=%b", e.name, val_out, page_out, frozen_out, e.val, e.page, e.frz);
            else n_pass++;
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 14; i++) send_msg(8'h00, 1'b0, 32'd0, 32'd0);
        clk1();
        push("total_14", 32'd14, 3'd0, 1'b0);
        e = sb_q.pop_front();
        n_total++;
        if ({val_out, page_out, frozen_out} !== {e.val, e.page, e.frz})
            $display("FAIL %s: val=%0h page=%0d frozen=%b, want val=%0h page=%0d frozen=%b", e.name, val_out, page_out, frozen_out, e.val, e.page, e.frz);
        else n_pass++;
        n_total++;
        if (sat_val !== 4'd14) $display("FAIL narrow_below_max: val=%0h, want e", sat_val);
        else n_pass++;
        for (int i = 0; i < 3; i++) send_msg(8'h00, 1'b0, 32'd0, 32'd0);
        clk1();
        push("total_17", 32'd17, 3'd0, 1'b0);
        e = sb_q.pop_front();
        n_total++;
        if ({val_out, page_out, frozen_out} !== {e.val, e.page, e.frz})
            $display("FAIL %s: val=%0h page=%0d frozen=%b, want val=%0h page=%0d frozen=%b", e.name, val_out, page_out, frozen_out, e.val, e.page, e.frz);
        else n_pass++;
        n_total++;
        if (sat_val !== 4'hF) $display("FAIL narrow_saturate: val=%0h, want f", sat_val);
        else n_pass++;
    endtask

    task automatic test_freeze();
        logic [31:0] sv [6];
        sv = '{32'd10, 32'd10, 32'd209, 32'd309, 32'd0, 32'h41};
        do_reset();
        for (int i = 0; i < 10; i++) send_msg(8'h41, 1'b0, 32'd200 + 32'(i), 32'd300 + 32'(i));
        btn_freeze_in = 1'b1;
        clk1();
        btn_freeze_in = 1'b0;
        for (int i = 0; i < 5; i++) send_msg(8'h41, 1'b0, 32'd500 + 32'(i), 32'd600 + 32'(i));
        clk1();
        push("frozen_holds_total", 32'd10, 3'd0, 1'b1);
        e = sb_q.pop_front();
        n_total++;
        if ({val_out, page_out, frozen_out} !== {e.val, e.page, e.frz})
            $display("FAIL %s: val=%0h page=%0d frozen=%b, want val=%0h page=%0d frozen=%b", e.name, val_out, page_out, frozen_out, e.val, e.page, e.frz);
        else n_pass++;
        for (int p = 1; p <= 6; p++) begin
            press_next();
            push("frozen_page", sv[p % 6], 3'(p % 6), 1'b1);
            e = sb_q.pop_front();
            n_total++;
            if ({val_out, page_out, frozen_out} !== {e.val, e.page, e.frz})
                $display("FAIL %s: val=%0h page=%0d frozen=%b, want val=%0h page=%0d frozen=%b", e.name, val_out, page_out, frozen_out, e.val, e.page, e.frz);
            else n_pass++;
        end
        btn_freeze_in = 1'b1;
        clk1();
        btn_freeze_in = 1'b0;
        push("unfreeze_lag", 32'd10, 3'd0, 1'b0);
        push("unfreeze_live", 32'd15, 3'd0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            e = sb_q.pop_front();
            n_total++;
            if ({val_out, page_out, frozen_out} !== {e.val, e.page, e.frz})
                $display("FAIL %s: val=%0h page=%0d frozen=%b, want val=%0h page=%0d frozen=%b", e.name, val_out, page_out, frozen_out, e.val, e.page, e.frz);
            else n_pass++;
            clk1();
        end
    endtask

    task automatic test_clear();
        btn_clear_in = 1'b1;
        send_msg(8'h41, 1'b0, 32'd1, 32'd1);
        btn_clear_in = 1'b0;
        clk1();
        push("clear_beats_msg", 32'd0, 3'd0, 1'b0);
        for (int p = 1; p < 6; p++) push("cleared_page", 32'd0, 3'(p), 1'b0);
        for (int p = 0; p < 6; p++) begin
            e = sb_q.pop_front();
            n_total++;
            if ({val_out, page_out, frozen_out} !== {e.val, e.page, e.frz})
                $display("FAIL %s: val=%0h page=%0d frozen=%b, want val=%0h page=%0d frozen=%b", e.name, val_out, page_out, frozen_out, e.val, e.page, e.frz);
            else n_pass++;
            if (p < 5) press_next();
        end
        for (int k = 1; k <= 6; k++) begin
            press_next();
            n_total++;
            if (page_out !== 3'((5 + k) % 6)) $display("FAIL page_wrap: page=%0d, want %0d", page_out, (5 + k) % 6);
            else n_pass++;
        end
    endtask

    task automatic test_clear_freeze();
        for (int i = 0; i < 3; i++) send_msg(8'h41, 1'b0, 32'd7, 32'd8);
        press_next();
        push("pre_clear_total", 32'd3, 3'd0, 1'b0);
        e = sb_q.pop_front();
        n_total++;
        if ({val_out, page_out, frozen_out} !== {e.val, e.page, e.frz})
            $display("FAIL %s: val=%0h page=%0d frozen=%b, want val=%0h page=%0d frozen=%b", e.name, val_out, page_out, frozen_out, e.val, e.page, e.frz);
        else n_pass++;
        btn_clear_in  = 1'b1;
        btn_freeze_in = 1'b1;
        clk1();
        btn_clear_in  = 1'b0;
        btn_freeze_in = 1'b0;
        clk1();
        push("snapshot_pre_clear", 32'd3, 3'd0, 1'b1);
        e = sb_q.pop_front();
        n_total++;
        if ({val_out, page_out, frozen_out} !== {e.val, e.page, e.frz})
            $display("FAIL %s: val=%0h page=%0d frozen=%b, want val=%0h page=%0d frozen=%b", e.name, val_out, page_out, frozen_out, e.val, e.page, e.frz);
        else n_pass++;
        btn_freeze_in = 1'b1;
        clk1();
        btn_freeze_in = 1'b0;
        clk1();
        push("live_was_cleared", 32'd0, 3'd0, 1'b0);
        e = sb_q.pop_front();
        n_total++;
        if ({val_out, page_out, frozen_out} !== {e.val, e.page, e.frz})
            $display("FAIL %s: val=%0h page=%0d frozen=%b, want val=%0h page=%0d frozen=%b", e.name, val_out, page_out, frozen_out, e.val, e.page, e.frz);
        else n_pass++;
    endtask

    task automatic test_freeze_next();
        do_reset();
        send_msg(8'h41, 1'b0, 32'd1000, 32'd2000);
        send_msg(8'h41, 1'b0, 32'd1001, 32'd2001);
        press_next();
        press_next();
        push("page2_live", 32'd1001, 3'd2, 1'b0);
        btn_next_in   = 1'b1;
        btn_freeze_in = 1'b1;
        e = sb_q.pop_front();
        n_total++;
        if ({val_out, page_out, frozen_out} !== {e.val, e.page, e.frz})
            $display("FAIL %s: val=%0h page=%0d frozen=%b, want val=%0h page=%0d frozen=%b", e.name, val_out, page_out, frozen_out, e.val, e.page, e.frz);
        else n_pass++;
        clk1();
        btn_next_in   = 1'b0;
        btn_freeze_in = 1'b0;
        push("both_edges_lag", 32'd1001, 3'd3, 1'b1);
        push("snapshot_qty", 32'd2001, 3'd3, 1'b1);
        for (int k = 0; k < 2; k++) begin
            e = sb_q.pop_front();
            n_total++;
            if ({val_out, page_out, frozen_out} !== {e.val, e.page, e.frz})
                $display("FAIL %s: val=%0h page=%0d frozen=%b, want val=%0h page=%0d frozen=%b", e.name, val_out, page_out, frozen_out, e.val, e.page, e.frz);
            else n_pass++;
            clk1();
        end
        send_msg(8'h41, 1'b0, 32'd5, 32'd6);
        clk1();
        push("snapshot_stable", 32'd2001, 3'd3, 1'b1);
        e = sb_q.pop_front();
        n_total++;
        if ({val_out, page_out, frozen_out} !== {e.val, e.page, e.frz})
            $display("FAIL %s: val=%0h page=%0d frozen=%b, want val=%0h page=%0d frozen=%b", e.name, val_out, page_out, frozen_out, e.val, e.page, e.frz);
        else n_pass++;
    endtask

    initial begin
        rst_in        = 1'b1;
        msg_valid_in  = 1'b0;
        msg_type_in   = 8'h00;
        msg_err_in    = 1'b0;
        price_in      = 32'd0;
        qty_in        = 32'd0;
        btn_next_in   = 1'b0;
        btn_freeze_in = 1'b0;
        btn_clear_in  = 1'b0;
        test_reset();
        test_pages();
        test_saturation();
        test_freeze();
        test_clear();
        test_clear_freeze();
        test_freeze_next();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
